bsg_manycore_mem_responder: RTL and testbench

Endpoint stage directly downstream of the manycore request-packet definitions. Consumes one decoded request (op, load_info, reg_id, source coordinates) at a time and executes it against a 1-cycle-latency 1RW word SRAM. Produces the matching return packet fields, with the return type selected per the team's return rules. Sits between the network endpoint's request FIFO and its return-packet injector, in front of a local data memory.

---
 rtl/bsg_manycore_mem_responder_pkg.sv | 66 ++++++
 rtl/bsg_manycore_mem_responder_amo_alu.sv | 34 +++
 rtl/bsg_manycore_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_bsg_manycore_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared manycore endpoint types: request opcodes, load info, return types,
// responder FSM states, and the load_select helper for sub-word loads.
package bsg_manycore_mem_responder_pkg;

    // Request opcodes; encodings 13-15 are unsupported and answered with a credit.
    typedef enum logic [3:0] {
        e_remote_load    = 4'd0,
        e_remote_store   = 4'd1,
        e_remote_sw      = 4'd2,
        e_cache_op       = 4'd3,
        e_remote_amoswap = 4'd4,
        e_remote_amoadd  = 4'd5,
        e_remote_amoxor  = 4'd6,
        e_remote_amoand  = 4'd7,
        e_remote_amoor   = 4'd8,
        e_remote_amomin  = 4'd9,
        e_remote_amomax  = 4'd10,
        e_remote_amominu = 4'd11,
        e_remote_amomaxu = 4'd12
    } bsg_manycore_packet_op_e;

    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    typedef enum logic [1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_read = 2'd1,
        e_resp = 2'd2
    } bsg_manycore_mem_responder_state_e;

    // True for every atomic opcode.
    function automatic logic is_amo(input logic [3:0] op);
        return (op >= e_remote_amoswap) && (op <= e_remote_amomaxu);
    endfunction

    // Extract and extend the loaded sub-word; fetches and float writebacks take the raw word.
    function automatic logic [31:0] load_select(input logic [31:0] word,
                                                input bsg_manycore_load_info_s li);
        logic [7:0]  lane;
        logic [15:0] half;
        lane = word[8*li.part_sel +: 8];
        half = li.part_sel[1] ? word[31:16] : word[15:0];
        if (li.icache_fetch || li.float_wb)
            return word;
        else if (li.is_byte_op)
            return li.is_unsigned_op ? {24'b0, lane} : {{24{lane[7]}}, lane};
        else if (li.is_hex_op)
            return li.is_unsigned_op ? {16'b0, half} : {{16{half[15]}}, half};
        else
            return word;
    endfunction

endpackage

// File: rtl/bsg_manycore_mem_responder_amo_alu.sv
// Combinational 32-bit AMO ALU: computes the value written back for an atomic op.
module bsg_manycore_amo_alu
    import bsg_manycore_mem_responder_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_old,
    input  logic [31:0] i_operand,
    output logic [31:0] o_new
);

    logic signed [31:0] w_old_s;
    logic signed [31:0] w_opd_s;

    assign w_old_s = i_old;
    assign w_opd_s = i_operand;

    // Select the new memory value; min/max compare signed, minu/maxu unsigned.
    always_comb begin
        o_new = i_old;
        case (i_op)
            e_remote_amoswap: o_new = i_operand;
            e_remote_amoadd:  o_new = i_old + i_operand;
            e_remote_amoxor:  o_new = i_old ^ i_operand;
            e_remote_amoand:  o_new = i_old & i_operand;
            e_remote_amoor:   o_new = i_old | i_operand;
            e_remote_amomin:  o_new = (w_old_s < w_opd_s) ? i_old : i_operand;
            e_remote_amomax:  o_new = (w_old_s > w_opd_s) ? i_old : i_operand;
            e_remote_amominu: o_new = (i_old < i_operand) ? i_old : i_operand;
            e_remote_amomaxu: o_new = (i_old > i_operand) ? i_old : i_operand;
            default:          o_new = i_old;
        endcase
    end

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Manycore memory endpoint: executes one request at a time against a 1-cycle 1RW SRAM
// and presents the return packet until consumed.
// Optional: define BSG_MANYCORE_MEM_RESPONDER_AMO_EN to execute atomics; otherwise
// atomics return int_wb with zero data and never touch the SRAM.
module bsg_manycore_mem_responder
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 10,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [3:0]                op_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [3:0]                mask_i,
    input  logic [4:0]                reg_id_i,
    input  logic [6:0]                load_info_i,
    input  logic [x_cord_width_p-1:0] src_x_cord_i,
    input  logic [y_cord_width_p-1:0] src_y_cord_i,
    output logic                      v_o,
    output logic [1:0]                pkt_type_o,
    output logic [data_width_p-1:0]   ret_data_o,
    output logic [4:0]                ret_reg_id_o,
    output logic [x_cord_width_p-1:0] ret_x_cord_o,
    output logic [y_cord_width_p-1:0] ret_y_cord_o,
    input  logic                      yumi_i,
    output logic                      mem_v_o,
    output logic                      mem_w_o,
    output logic [addr_width_p-1:0]   mem_addr_o,
    output logic [data_width_p-1:0]   mem_data_o,
    output logic [3:0]                mem_mask_o,
    input  logic [data_width_p-1:0]   mem_data_i
);

    bsg_manycore_mem_responder_state_e r_state;
    logic [3:0]                 r_op;
    logic [addr_width_p-1:0]    r_addr;
    logic [data_width_p-1:0]    r_data;
    logic [4:0]                 r_reg_id;
    bsg_manycore_load_info_s    r_load_info;
    logic [x_cord_width_p-1:0]  r_x_cord;
    logic [y_cord_width_p-1:0]  r_y_cord;
    logic                       r_v;
    logic [1:0]                 r_pkt_type;
    logic [data_width_p-1:0]    r_ret_data;

    logic                       w_accept;
    logic                       w_acc_read;
    logic [1:0]                 w_acc_type;
    logic [data_width_p-1:0]    w_amo_new;
    bsg_manycore_load_info_s    w_li_in;

`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
    localparam bit amo_en_lp = 1'b1;

    bsg_manycore_amo_alu u_amo_alu (
        .i_op      (r_op),
        .i_old     (mem_data_i),
        .i_operand (r_data),
        .o_new     (w_amo_new)
    );
`else
    localparam bit amo_en_lp = 1'b0;

    // No ALU: the write-back path is never enabled, so just park it on the operand.
    assign w_amo_new = r_data;
`endif

    assign w_li_in    = load_info_i;
    assign ready_o    = (r_state == e_idle);
    assign w_accept   = ready_o & v_i;
    // Loads, and atomics when enabled, need the SRAM read data before responding.
    assign w_acc_read = (op_i == e_remote_load) || (amo_en_lp && is_amo(op_i));
    // Atomics always answer int_wb; everything that responds immediately otherwise is a credit.
    assign w_acc_type = is_amo(op_i) ? e_return_int_wb : e_return_credit;

    assign v_o          = r_v;
    assign pkt_type_o   = r_pkt_type;
    assign ret_data_o   = r_ret_data;
    assign ret_reg_id_o = r_reg_id;
    assign ret_x_cord_o = r_x_cord;
    assign ret_y_cord_o = r_y_cord;

    // SRAM port: request-side access on accept, AMO write-back during READ; idle under reset.
    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = addr_i;
        mem_data_o = data_i;
        mem_mask_o = 4'hF;
        if (reset_n_i) begin
            if (w_accept) begin
                case (op_i)
                    e_remote_load:  mem_v_o = 1'b1;
                    e_remote_store: begin
                        mem_v_o    = 1'b1;
                        mem_w_o    = 1'b1;
                        mem_mask_o = mask_i;
                    end
                    e_remote_sw: begin
                        mem_v_o = 1'b1;
                        mem_w_o = 1'b1;
                    end
                    default:        mem_v_o = amo_en_lp && is_amo(op_i);
                endcase
            end else if ((r_state == e_read) && amo_en_lp && is_amo(r_op)) begin
                mem_v_o    = 1'b1;
                mem_w_o    = 1'b1;
                mem_addr_o = r_addr;
                mem_data_o = w_amo_new;
            end
        end
    end

    // Request FSM: latch on accept, capture read data in READ, hold the return until yumi.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_idle;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_reg_id    <= '0;
            r_load_info <= '0;
            r_x_cord    <= '0;
            r_y_cord    <= '0;
            r_v         <= 1'b0;
            r_pkt_type  <= e_return_credit;
            r_ret_data  <= '0;
        end else begin
            case (r_state)
                e_idle: begin
                    if (v_i) begin
                        r_op        <= op_i;
                        r_addr      <= addr_i;
                        r_data      <= data_i;
                        r_reg_id    <= reg_id_i;
                        r_load_info <= w_li_in;
                        r_x_cord    <= src_x_cord_i;
                        r_y_cord    <= src_y_cord_i;
                        r_ret_data  <= '0;
                        r_pkt_type  <= w_acc_type;
                        if (w_acc_read) begin
                            r_state <= e_read;
                        end else begin
                            r_state <= e_resp;
                            r_v     <= 1'b1;
                        end
                    end
                end
                e_read: begin
                    if (is_amo(r_op)) begin
                        r_ret_data <= mem_data_i;
                        r_pkt_type <= e_return_int_wb;
                    end else begin
                        r_ret_data <= load_select(mem_data_i, r_load_info);
                        if (r_load_info.icache_fetch)
                            r_pkt_type <= e_return_ifetch;
                        else if (r_load_info.float_wb)
                            r_pkt_type <= e_return_float_wb;
                        else
                            r_pkt_type <= e_return_int_wb;
                    end
                    r_v     <= 1'b1;
                    r_state <= e_resp;
                end
                e_resp: begin
                    if (yumi_i) begin
                        r_v     <= 1'b0;
                        r_state <= e_idle;
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Scoreboard bench for bsg_manycore_mem_responder: directed cases plus randomized requests,
// expectations from a word-array reference model, returns checked by an independent monitor.
module tb_bsg_manycore_mem_responder;
    import bsg_manycore_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [9:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic [4:0]  reg_id_i;
    logic [6:0]  load_info_i;
    logic [6:0]  src_x_cord_i;
    logic [6:0]  src_y_cord_i;
    logic        v_o;
    logic [1:0]  pkt_type_o;
    logic [31:0] ret_data_o;
    logic [4:0]  ret_reg_id_o;
    logic [6:0]  ret_x_cord_o;
    logic [6:0]  ret_y_cord_o;
    logic        yumi_i;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_mask_o;
    logic [31:0] mem_data_i;

    bsg_manycore_mem_responder dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .op_i(op_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
        .reg_id_i(reg_id_i), .load_info_i(load_info_i),
        .src_x_cord_i(src_x_cord_i), .src_y_cord_i(src_y_cord_i),
        .v_o(v_o), .pkt_type_o(pkt_type_o), .ret_data_o(ret_data_o),
        .ret_reg_id_o(ret_reg_id_o), .ret_x_cord_o(ret_x_cord_o), .ret_y_cord_o(ret_y_cord_o),
        .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM attached to the DUT (environment, 1-cycle read latency).
    bit [31:0] sram [0:1023];
    bit [31:0] ref_mem [0:1023];

    function automatic bit [31:0] merge(bit [31:0] old, logic [31:0] d, logic [3:0] m);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_data_o, mem_mask_o);
            else         mem_data_i <= sram[mem_addr_o];
        end
    end

    typedef struct {
        logic [1:0]  t;
        logic [31:0] d;
        logic [4:0]  id;
        logic [6:0]  x;
        logic [6:0]  y;
        int          issue_cyc;
        int          lat;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [6:0] mk_li(bit f, bit ic, bit u, bit b, bit h, logic [1:0] ps);
        return {f, ic, u, b, h, ps};
    endfunction

    // Reference load result built from shifts and masks of the stored word.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [6:0] li);
        logic [31:0] v;
        if (li[6] || li[5]) return w;
        if (li[3]) begin
            v = (w >> (8 * li[1:0])) & 32'hFF;
            if (!li[4] && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (li[2]) begin
            v = (w >> (16 * li[1])) & 32'hFFFF;
            if (!li[4] && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_amo(logic [3:0] op, logic [31:0] o, logic [31:0] d);
        case (op)
            4'd4:  return d;
            4'd5:  return o + d;
            4'd6:  return o ^ d;
            4'd7:  return o & d;
            4'd8:  return o | d;
            4'd9:  return ($signed(o) <= $signed(d)) ? o : d;
            4'd10: return ($signed(o) >= $signed(d)) ? o : d;
            4'd11: return (o <= d) ? o : d;
            default: return (o >= d) ? o : d;
        endcase
    endfunction

    // Wait for ready (driving ignored junk meanwhile), issue one request, update the model.
    task automatic issue(input logic [3:0] op, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [6:0] li, input logic [4:0] id,
                         input bit lit, input logic [1:0] lt, input logic [31:0] ld, input bit push);
        exp_t e;
        int   n = 0;
        while (!ready_o) begin
            v_i = 1'($urandom_range(1, 0));
            op_i = 4'($urandom); addr_i = 10'($urandom); data_i = $urandom;
            mask_i = 4'($urandom); reg_id_i = 5'($urandom); load_info_i = 7'($urandom);
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk(1'b0, "ready_timeout", 64'(n), 64'd200);
                v_i = 1'b0;
                return;
            end
        end
        op_i = op; addr_i = a; data_i = d; mask_i = m; load_info_i = li; reg_id_i = id;
        src_x_cord_i = 7'($urandom); src_y_cord_i = 7'($urandom);
        v_i = 1'b1;
        e.id = id; e.x = src_x_cord_i; e.y = src_y_cord_i; e.issue_cyc = cyc;
        e.t = 2'd0; e.d = 32'd0; e.lat = 1;
        if (op == 4'd0) begin
            e.lat = 2;
            e.d = ref_load(ref_mem[a], li);
            e.t = li[5] ? 2'd3 : (li[6] ? 2'd2 : 2'd1);
        end else if (op == 4'd1) begin
            ref_mem[a] = merge(ref_mem[a], d, m);
        end else if (op == 4'd2) begin
            ref_mem[a] = d;
        end else if (op >= 4'd4 && op <= 4'd12) begin
            e.t = 2'd1;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
            e.lat = 2;
            e.d = ref_mem[a];
            ref_mem[a] = ref_amo(op, ref_mem[a], d);
`endif
        end
        if (lit) begin e.t = lt; e.d = ld; end
        if (push) q.push_back(e);
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 || !ready_o) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk(1'b0, "drain_timeout", 64'(q.size()), 64'd0);
                return;
            end
        end
    endtask

    // Monitor: compares the presented return against the queue head every cycle it is held.
    initial begin : monitor
        int   shown  = 0;
        bit   popped = 0;
        exp_t e;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            if (popped) begin
                chk(!v_o && ready_o, "after_yumi_ready", {v_o, ready_o}, 64'b01);
                popped = 0;
            end
            yumi_i = 1'b0;
            if (reset_n_i && v_o) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_v_o", 64'(ret_data_o), 64'd0);
                end else begin
                    e = q[0];
                    if (shown == 0) chk(cyc - e.issue_cyc == e.lat, "latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
                    chk(pkt_type_o == e.t, "pkt_type", 64'(pkt_type_o), 64'(e.t));
                    chk(ret_data_o == e.d, "ret_data", 64'(ret_data_o), 64'(e.d));
                    chk({ret_reg_id_o, ret_x_cord_o, ret_y_cord_o} == {e.id, e.x, e.y}, "ret_id_xy",
                        64'({ret_reg_id_o, ret_x_cord_o, ret_y_cord_o}), 64'({e.id, e.x, e.y}));
                    chk(!ready_o, "ready_while_v_o", 64'(ready_o), 64'd0);
                    shown++;
                    if ((e.id == 5'd31) ? (shown > 5) : ($urandom_range(1, 0) == 1)) begin
                        yumi_i = 1'b1;
                        void'(q.pop_front());
                        shown  = 0;
                        popped = 1;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [6:0] li;
        logic [3:0] op;
        reset_n_i = 1'b0; v_i = 1'b0; op_i = '0; addr_i = '0; data_i = '0; mask_i = '0;
        reg_id_i = '0; load_info_i = '0; src_x_cord_i = '0; src_y_cord_i = '0;
        repeat (3) @(negedge clk);
        chk(v_o == 1'b0 && mem_v_o == 1'b0, "reset_v", {v_o, mem_v_o}, 64'd0);
        chk(ready_o == 1'b1, "reset_ready", 64'(ready_o), 64'd1);
        chk({pkt_type_o, ret_data_o, ret_reg_id_o, ret_x_cord_o, ret_y_cord_o} == '0, "reset_fields",
            64'({pkt_type_o, ret_data_o, ret_reg_id_o, ret_x_cord_o, ret_y_cord_o}), 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk);

        // Byte loads: signed and unsigned lane 3.
        issue(4'd2, 10'd5, 32'h80FF_1234, 4'h0, 7'd0, 5'd1, 1, 2'd0, 32'h0, 1);
        issue(4'd0, 10'd5, 32'h0, 4'h0, mk_li(0,0,0,1,0,2'd3), 5'd2, 1, 2'd1, 32'hFFFF_FF80, 1);
        issue(4'd0, 10'd5, 32'h0, 4'h0, mk_li(0,0,1,1,0,2'd3), 5'd3, 1, 2'd1, 32'h0000_0080, 1);
        // Masked store then word load.
        issue(4'd2, 10'd2, 32'h0, 4'h0, 7'd0, 5'd4, 1, 2'd0, 32'h0, 1);
        issue(4'd1, 10'd2, 32'hAABB_CCDD, 4'b0101, 7'd0, 5'd5, 1, 2'd0, 32'h0, 1);
        issue(4'd0, 10'd2, 32'h0, 4'h0, 7'd0, 5'd6, 1, 2'd1, 32'h00BB_00DD, 1);
        // Atomic min / minu on an all-ones word.
        issue(4'd2, 10'd7, 32'hFFFF_FFFF, 4'h0, 7'd0, 5'd7, 1, 2'd0, 32'h0, 1);
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
        issue(4'd9, 10'd7, 32'd1, 4'h0, 7'd0, 5'd8, 1, 2'd1, 32'hFFFF_FFFF, 1);
        issue(4'd0, 10'd7, 32'h0, 4'h0, 7'd0, 5'd9, 1, 2'd1, 32'hFFFF_FFFF, 1);
        issue(4'd11, 10'd7, 32'd1, 4'h0, 7'd0, 5'd10, 1, 2'd1, 32'hFFFF_FFFF, 1);
        issue(4'd0, 10'd7, 32'h0, 4'h0, 7'd0, 5'd11, 1, 2'd1, 32'h0000_0001, 1);
`else
        issue(4'd9, 10'd7, 32'd1, 4'h0, 7'd0, 5'd8, 1, 2'd1, 32'h0, 1);
        issue(4'd0, 10'd7, 32'h0, 4'h0, 7'd0, 5'd9, 1, 2'd1, 32'hFFFF_FFFF, 1);
        issue(4'd11, 10'd7, 32'd1, 4'h0, 7'd0, 5'd10, 1, 2'd1, 32'h0, 1);
        issue(4'd0, 10'd7, 32'h0, 4'h0, 7'd0, 5'd11, 1, 2'd1, 32'hFFFF_FFFF, 1);
`endif
        // Return-type priority: icache_fetch beats float_wb, raw word returned.
        issue(4'd0, 10'd5, 32'h0, 4'h0, mk_li(1,1,0,1,0,2'd3), 5'd12, 1, 2'd3, 32'h80FF_1234, 1);
        // Cache op and unsupported opcode give credits.
        issue(4'd3, 10'd5, 32'h1234, 4'hF, 7'd0, 5'd13, 1, 2'd0, 32'h0, 1);
        issue(4'd14, 10'd5, 32'h1234, 4'hF, 7'd0, 5'd14, 1, 2'd0, 32'h0, 1);
        // Backpressure: reg_id 31 is held for 5 cycles by the monitor.
        issue(4'd0, 10'd5, 32'h0, 4'h0, 7'd0, 5'd31, 1, 2'd1, 32'h80FF_1234, 1);
        drain();

        // Asynchronous reset while the load sits in READ: no return must appear.
        issue(4'd0, 10'd5, 32'h0, 4'h0, 7'd0, 5'd20, 0, 2'd0, 32'h0, 0);
        reset_n_i = 1'b0;
        #1;
        chk(v_o == 1'b0 && mem_v_o == 1'b0, "abort_v", {v_o, mem_v_o}, 64'd0);
        chk(ready_o == 1'b1, "abort_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        chk(ready_o == 1'b1, "post_reset_ready", 64'(ready_o), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk(v_o == 1'b0, "post_reset_no_ret", 64'(v_o), 64'd0);
        end

        // Randomized traffic over a small address window.
        for (int i = 0; i < 300; i++) begin
            li = 7'($urandom);
            if (li[3]) li[2] = 1'b0;
            op = 4'($urandom_range(15, 0));
            issue(op, 10'($urandom_range(15, 0)), $urandom, 4'($urandom), li,
                  5'($urandom_range(30, 0)), 0, 2'd0, 32'h0, 1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
